// File: rtl/framebuffer_ram.sv
// rtl/framebuffer_ram.sv - simple-dual-port pixel memory with clear engine, read pipeline and bounds checks
// Optional macro FB_RDW_BYPASS_EN: same-cycle write data is forwarded to a read of the same address.
module framebuffer_ram #(
  parameter int DATA_WIDTH   = 3,
  parameter int ADDR_WIDTH   = 20,
  parameter int MEM_SIZE     = 307200,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rd_valid,
  input  logic                  clear_start,
  input  logic [DATA_WIDTH-1:0] clear_color,
  output logic                  clear_busy,
  output logic                  clear_done
);

  // Index width of the storage array; in-range addresses fit in these low bits.
  localparam int                  LP_IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0] LP_SIZE  = (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(MEM_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_color;
  logic [DATA_WIDTH-1:0] r_mem [0:MEM_SIZE-1];

  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic                  w_fill_wr;
  logic                  w_user_wr;
  logic                  w_wr_en;
  logic [LP_IDX_W-1:0]   w_wr_idx;
  logic [LP_IDX_W-1:0]   w_rd_idx;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] r_rd_data1;
  logic                  r_rd_v1;

  assign w_wr_in_range = ({1'b0, write_addr} < LP_SIZE);
  assign w_rd_in_range = ({1'b0, read_addr} < LP_SIZE);
  assign w_rd_idx      = read_addr[LP_IDX_W-1:0];

  // The fill engine owns the write port while clearing; user writes are only taken when ready.
  assign w_fill_wr = (r_state == S_CLEAR);
  assign w_user_wr = we && wr_ready && w_wr_in_range;
  assign w_wr_en   = !rst && (w_fill_wr || w_user_wr);
  assign w_wr_idx  = w_fill_wr ? r_cnt[LP_IDX_W-1:0] : write_addr[LP_IDX_W-1:0];
  assign w_wr_data = w_fill_wr ? r_color : din;

  // Clear FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Clear FSM next-state logic; a start request outside IDLE is ignored
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (clear_start) w_next = S_CLEAR;
      S_CLEAR: if (r_cnt == LP_LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Clear FSM outputs decoded from state
  always_comb begin
    wr_ready   = (r_state != S_CLEAR);
    clear_busy = (r_state == S_CLEAR);
    clear_done = (r_state == S_DONE);
  end

  // Fill counter and latched fill colour
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_color <= '0;
    end else if (r_state == S_IDLE && clear_start) begin
      r_cnt   <= '0;
      r_color <= clear_color;
    end else if (r_state == S_CLEAR) begin
      r_cnt   <= r_cnt + ADDR_WIDTH'(1);
    end
  end

  // Single shared write port (no reset: contents survive rst)
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_idx] <= w_wr_data;
  end

  // Read mux ahead of the pipeline: out-of-range reads return 0
  always_comb begin
    w_rd_data = '0;
    if (w_rd_in_range) begin
      w_rd_data = r_mem[w_rd_idx];
`ifdef FB_RDW_BYPASS_EN
      if (w_wr_en && (w_wr_idx == w_rd_idx)) w_rd_data = w_wr_data;
`endif
    end
  end

  // First read stage: data holds when no request is made
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data1 <= '0;
      r_rd_v1    <= 1'b0;
    end else begin
      r_rd_v1 <= rd_en;
      if (rd_en) r_rd_data1 <= w_rd_data;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] r_rd_data2;
      logic                  r_rd_v2;

      // Optional second output register
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rd_data2 <= '0;
          r_rd_v2    <= 1'b0;
        end else begin
          r_rd_v2 <= r_rd_v1;
          if (r_rd_v1) r_rd_data2 <= r_rd_data1;
        end
      end

      assign dout     = r_rd_data2;
      assign rd_valid = r_rd_v2;
    end else begin : g_lat1
      assign dout     = r_rd_data1;
      assign rd_valid = r_rd_v1;
    end
  endgenerate

endmodule

// File: tb/tb_framebuffer_ram.sv
// tb/tb_framebuffer_ram.sv - randomized self-checking bench for framebuffer_ram
module tb_framebuffer_ram;
  parameter int RL = 1;
  localparam int MS = 16;

  logic        clk = 1'b0;
  logic        rst, we, rd_en, clear_start;
  logic [19:0] write_addr, read_addr;
  logic [2:0]  din, clear_color, dout;
  logic        wr_ready, rd_valid, clear_busy, clear_done;

  framebuffer_ram #(
    .DATA_WIDTH(3), .ADDR_WIDTH(20), .MEM_SIZE(MS), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .din(din),
    .wr_ready(wr_ready), .rd_en(rd_en), .read_addr(read_addr), .dout(dout),
    .rd_valid(rd_valid), .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  typedef struct {int due; int d;} rd_t;
  rd_t rq[$];

  int m_mem[MS];
  bit m_busy, m_done;
  int m_fill, m_color, m_last;
  int cyc_n, n_checks, n_errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc_n, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the reference model, then compare outputs
  task automatic cyc(input bit t_rst, input bit t_we, input int wa, input int d,
                     input bit t_rd, input int ra, input bit t_cs, input int cc);
    bit acc, fin, wr_hit, ev;
    int wr_a, wr_d, rv, ed;
    rd_t e;
    rst = t_rst; we = t_we; write_addr = 20'(wa); din = 3'(d);
    rd_en = t_rd; read_addr = 20'(ra); clear_start = t_cs; clear_color = 3'(cc);
    cyc_n++;
    if (t_rst) begin
      m_busy = 0; m_done = 0; m_last = 0; rq.delete();
    end else begin
      wr_hit = 0; wr_a = 0; wr_d = 0;
      if (m_busy) begin
        wr_hit = 1; wr_a = m_fill; wr_d = m_color;
      end else if (t_we && wa < MS) begin
        wr_hit = 1; wr_a = wa; wr_d = d;
      end
      if (t_rd) begin
        rv = (ra < MS) ? m_mem[ra] : 0;
`ifdef FB_RDW_BYPASS_EN
        if (wr_hit && wr_a == ra) rv = wr_d;
`endif
        rq.push_back('{cyc_n + RL - 1, rv});
      end
      if (wr_hit) m_mem[wr_a] = wr_d;
      acc = t_cs && !m_busy && !m_done;
      fin = m_busy && (m_fill == MS - 1);
      if (m_busy) m_fill++;
      m_done = fin;
      m_busy = acc || (m_busy && !fin);
      if (acc) begin
        m_fill = 0; m_color = cc;
      end
    end
    @(posedge clk); #1;
    ev = 0; ed = m_last;
    if (rq.size() > 0 && rq[0].due == cyc_n) begin
      e = rq.pop_front();
      ev = 1; ed = e.d; m_last = ed;
    end
    chk("rd_valid", 32'(rd_valid), 32'(ev));
    chk("dout", 32'(dout), 32'(ed));
    chk("clear_busy", 32'(clear_busy), 32'(m_busy));
    chk("clear_done", 32'(clear_done), 32'(m_done));
    chk("wr_ready", 32'(wr_ready), 32'(!m_busy));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int a, input int d);
    cyc(0, 1, a, d, 0, 0, 0, 0);
  endtask

  task automatic rd(input int a);
    cyc(0, 0, 0, 0, 1, a, 0, 0);
  endtask

  task automatic rd_all();
    for (int a = 0; a < MS; a++) rd(a);
    idle(RL);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc_n = 0; m_last = 0; m_fill = 0; m_color = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);

    for (int a = 0; a < MS; a++) wr(a, $urandom_range(0, 7));

    // basic write then read
    wr(5, 5); rd(5); idle(RL + 1);

    // out-of-range write and read
    wr(MS, 7); rd(0); rd(MS); rd(20'hFFFFF); idle(RL + 1);

    // same-cycle read and write to one address
    wr(10, 3);
    cyc(0, 1, 10, 6, 1, 10, 0, 0);
    rd(10); idle(RL + 1);

    // clear with colour 2; start coincides with a user write, restart and write attempts during busy
    cyc(0, 1, 3, 7, 0, 0, 1, 2);
    for (int i = 0; i < MS + 4; i++) begin
      if (i == 5)       cyc(0, 0, 0, 0, 1, 1, 1, 4);
      else if (i == 10) cyc(0, 1, 2, 7, 1, 2, 0, 0);
      else              cyc(0, 0, 0, 0, 1, i % MS, 0, 0);
    end
    rd_all();

    // zero the memory, then abort a colour-1 clear after 8 fills
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    idle(MS + 2);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    idle(8);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    rd_all();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit r_rst, r_we, r_rd, r_cs;
      int wa, ra;
      r_rst = ($urandom_range(0, 299) == 0);
      r_we  = $urandom_range(0, 1);
      r_rd  = $urandom_range(0, 1);
      r_cs  = ($urandom_range(0, 59) == 0);
      wa = ($urandom_range(0, 15) == 0) ? 20'hFFFFF : $urandom_range(0, MS + 3);
      ra = ($urandom_range(0, 15) == 0) ? 20'hFFFFF : $urandom_range(0, MS + 3);
      cyc(r_rst, r_we, wa, $urandom_range(0, 7), r_rd, ra, r_cs, $urandom_range(0, 7));
    end
    idle(MS + 4);
    rd_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
